// File: rtl/axil_dm_cache.sv
// Direct-mapped, write-through, single-word-line cache between two AXI-Lite ports.
// Optional macro CACHE_WRITE_ALLOCATE_EN installs the line on an OKAY write miss.
//
// state   | meaning
// IDLE    | arbitrate read/write requests, apply flush
// LOOKUP  | registered tag compare on the latched request
// RD_AR   | issue manager read address
// RD_R    | wait for manager read data, fill on OKAY
// RD_RESP | present read data to the processor
// WR_REQ  | issue manager write address and data
// WR_B    | wait for manager write response, update on hit
// WR_RESP | present write response to the processor
module axil_dm_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] axil_awaddr_sbd,
  input  logic                  axil_awvalid_sbd,
  output logic                  axil_awready_sbd,
  input  logic [DATA_WIDTH-1:0] axil_wdata_sbd,
  input  logic                  axil_wvalid_sbd,
  output logic                  axil_wready_sbd,
  output logic [1:0]            axil_bresp_sbd,
  output logic                  axil_bvalid_sbd,
  input  logic                  axil_bready_sbd,
  input  logic [ADDR_WIDTH-1:0] axil_araddr_sbd,
  input  logic                  axil_arvalid_sbd,
  output logic                  axil_arready_sbd,
  output logic [DATA_WIDTH-1:0] axil_rdata_sbd,
  output logic [1:0]            axil_rresp_sbd,
  output logic                  axil_rvalid_sbd,
  input  logic                  axil_rready_sbd,
  output logic [ADDR_WIDTH-1:0] axil_awaddr_mng,
  output logic                  axil_awvalid_mng,
  input  logic                  axil_awready_mng,
  output logic [DATA_WIDTH-1:0] axil_wdata_mng,
  output logic                  axil_wvalid_mng,
  input  logic                  axil_wready_mng,
  input  logic [1:0]            axil_bresp_mng,
  input  logic                  axil_bvalid_mng,
  output logic                  axil_bready_mng,
  output logic [ADDR_WIDTH-1:0] axil_araddr_mng,
  output logic                  axil_arvalid_mng,
  input  logic                  axil_arready_mng,
  input  logic [DATA_WIDTH-1:0] axil_rdata_mng,
  input  logic [1:0]            axil_rresp_mng,
  input  logic                  axil_rvalid_mng,
  output logic                  axil_rready_mng
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, RD_AR, RD_R, RD_RESP, WR_REQ, WR_B, WR_RESP
  } state_t;

  state_t state_q, state_d;

  logic [NUM_SETS-1:0]   valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_SETS];
  logic [DATA_WIDTH-1:0] data_q [NUM_SETS];

  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_data_q;
  logic                  req_wr_q;
  logic                  prio_rd_q;
  logic                  flush_pend_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;
  logic                  aw_done_q;
  logic                  w_done_q;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             line_hit;
  logic             flush_now;
  logic             wr_pend;
  logic             rd_sel;
  logic             wr_sel;
  logic             fill_ok;
  logic             wr_ok;

  assign req_idx  = req_addr_q[OFF_W +: IDX_W];
  assign req_tag  = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign line_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // A flush seen in IDLE blocks acceptance for that cycle.
  assign flush_now = (state_q == IDLE) && (flush || flush_pend_q);
  assign wr_pend   = axil_awvalid_sbd && axil_wvalid_sbd;
  assign rd_sel    = (state_q == IDLE) && !flush_now && axil_arvalid_sbd &&
                     (!wr_pend || prio_rd_q);
  assign wr_sel    = (state_q == IDLE) && !flush_now && wr_pend && !rd_sel;

  assign fill_ok = (state_q == RD_R) && axil_rvalid_mng && (axil_rresp_mng == 2'b00);
  assign wr_ok   = (state_q == WR_B) && axil_bvalid_mng && (axil_bresp_mng == 2'b00);

  assign axil_araddr_mng = {req_addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign axil_awaddr_mng = req_addr_q;
  assign axil_wdata_mng  = req_data_q;
  assign axil_rdata_sbd  = rdata_q;
  assign axil_rresp_sbd  = resp_q;
  assign axil_bresp_sbd  = resp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    axil_arready_sbd = rd_sel;
    axil_awready_sbd = wr_sel;
    axil_wready_sbd  = wr_sel;
    axil_rvalid_sbd  = 1'b0;
    axil_bvalid_sbd  = 1'b0;
    axil_arvalid_mng = 1'b0;
    axil_rready_mng  = 1'b0;
    axil_awvalid_mng = 1'b0;
    axil_wvalid_mng  = 1'b0;
    axil_bready_mng  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_sel || wr_sel) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (req_wr_q)      state_d = WR_REQ;
        else if (line_hit) state_d = RD_RESP;
        else               state_d = RD_AR;
      end
      RD_AR: begin
        axil_arvalid_mng = 1'b1;
        if (axil_arready_mng) state_d = RD_R;
      end
      RD_R: begin
        axil_rready_mng = 1'b1;
        if (axil_rvalid_mng) state_d = RD_RESP;
      end
      RD_RESP: begin
        axil_rvalid_sbd = 1'b1;
        if (axil_rready_sbd) state_d = IDLE;
      end
      WR_REQ: begin
        axil_awvalid_mng = !aw_done_q;
        axil_wvalid_mng  = !w_done_q;
        if ((aw_done_q || axil_awready_mng) && (w_done_q || axil_wready_mng))
          state_d = WR_B;
      end
      WR_B: begin
        axil_bready_mng = 1'b1;
        if (axil_bvalid_mng) state_d = WR_RESP;
      end
      WR_RESP: begin
        axil_bvalid_sbd = 1'b1;
        if (axil_bready_sbd) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_wr_q     <= 1'b0;
      prio_rd_q    <= 1'b1;
      flush_pend_q <= 1'b0;
      rdata_q      <= '0;
      resp_q       <= 2'b00;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      if (flush_now)  flush_pend_q <= 1'b0;
      else if (flush) flush_pend_q <= 1'b1;

      if (flush_now) valid_q <= '0;
      else if (fill_ok) valid_q[req_idx] <= 1'b1;
`ifdef CACHE_WRITE_ALLOCATE_EN
      else if (wr_ok) valid_q[req_idx] <= 1'b1;
`endif

      if (rd_sel) begin
        req_addr_q <= axil_araddr_sbd;
        req_wr_q   <= 1'b0;
        prio_rd_q  <= 1'b0;
      end else if (wr_sel) begin
        req_addr_q <= axil_awaddr_sbd;
        req_data_q <= axil_wdata_sbd;
        req_wr_q   <= 1'b1;
        prio_rd_q  <= 1'b1;
      end

      case (state_q)
        LOOKUP: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (!req_wr_q && line_hit) begin
            rdata_q <= data_q[req_idx];
            resp_q  <= 2'b00;
          end
        end
        RD_R: begin
          if (axil_rvalid_mng) begin
            rdata_q <= axil_rdata_mng;
            resp_q  <= axil_rresp_mng;
          end
        end
        WR_REQ: begin
          if (axil_awready_mng) aw_done_q <= 1'b1;
          if (axil_wready_mng)  w_done_q  <= 1'b1;
        end
        WR_B: begin
          if (axil_bvalid_mng) resp_q <= axil_bresp_mng;
        end
        default: ;
      endcase
    end
  end

  // Tag/data storage needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_ok) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= axil_rdata_mng;
    end
`ifdef CACHE_WRITE_ALLOCATE_EN
    else if (wr_ok) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= req_data_q;
    end
`else
    else if (wr_ok && line_hit) begin
      data_q[req_idx] <= req_data_q;
    end
`endif
  end

endmodule
